unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters: the core's memory port (fetch, load, store) and the program loader/debug port. It serialises one transaction at a time, applies round-robin priority, drives the memory for a configurable read latency, and returns a one-cycle done pulse with registered read data. It sits between the core datapath's Adr/WriteData/ReadData path, the loader, and the memory macro. The core controller treats "done" as its memory-ready condition.

Parameters:
AW, 32, address width (byte address, passed through unchanged)
DW, 32, data width
READ_LATENCY, 1, cycles from the m_en cycle to valid m_rdata; legal range 1..15
CNT_W, 4, width of the latency counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
c_req  in  1  core request
c_we  in  1  core write enable (1 = store, 0 = read)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_gnt  out  1  core request accepted this cycle
c_done  out  1  core transaction complete (pulse)
c_rdata  out  DW  core read data, registered
l_req  in  1  loader request
l_we  in  1  loader write enable
l_addr  in  AW  loader address
l_wdata  in  DW  loader write data
l_gnt  out  1  loader request accepted this cycle
l_done  out  1  loader transaction complete (pulse)
l_rdata  out  DW  loader read data, registered
m_en  out  1  memory access strobe
m_we  out  1  memory write
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, last_owner=LOADER (so the core wins the first tie), counter=0, all outputs 0, c_rdata=l_rdata=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitration is combinational.
  - Only one request present: that requester is granted.
  - Both present: the requester that is not last_owner is granted.
  - The gnt for the winner is asserted in the same cycle. At the clock edge: owner, we, addr and wdata are captured, last_owner is updated, and state moves to ISSUE.
  - No request: stay in IDLE.
  - gnt is asserted only in IDLE, and never to both requesters at once.
- ISSUE (exactly 1 cycle): m_en=1, m_we=captured we, m_addr and m_wdata come from the captured registers.
  - Write: next state is RESP.
  - Read: counter is loaded with READ_LATENCY and next state is WAIT.
- WAIT: counter decrements each cycle. In the cycle where counter==1, m_rdata is captured into the owner's rdata register and state moves to RESP. m_en=0 throughout WAIT.
- RESP (1 cycle): owner's done=1, then state returns to IDLE.
  - Non-owner's rdata is unchanged.
  - On a write, the owner's rdata is also unchanged.
- Latency, with the gnt cycle as cycle 0:
  - Write: mem write in cycle 1, done in cycle 2.
  - Read: m_en in cycle 1, data valid at cycle 1+READ_LATENCY, done in cycle 2+READ_LATENCY.
  - Minimum spacing between grants is 3 cycles (write) or 3+READ_LATENCY cycles (read).
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until gnt. After gnt these may change freely.
  - req asserted while that requester's transaction is in flight is ignored until IDLE.
  - rdata is held stable until that requester's next read completes.
- m_addr, m_wdata and m_we may hold their last values outside ISSUE; only m_en qualifies them.
- Simultaneous events:
  - If RESP completes and req is still high, the request is re-arbitrated in the following IDLE cycle.
  - Round-robin guarantees that under continuous contention each requester is granted at least every second transaction.
- Reset mid-operation: the in-flight transaction is abandoned and no done is issued. m_en drops immediately (async). last_owner returns to LOADER.
- Illegal state encoding: return to IDLE with all strobes 0.

Decomposition:
- Package unified_mem_arb_pkg contains:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner encoding (OWN_CORE=0, OWN_LOADER=1);
  - the default widths.
- One sub-module, rr_arb2: a 2-way round-robin picker. Inputs are req[1:0] and last_owner; outputs are a one-hot grant and the winner index. It is purely combinational.

Test Plan:
- Core read of 0x0000_0010 with mem[0x10]=0xDEAD_BEEF, READ_LATENCY=1, c_req pulsed at cycle 0 -> c_gnt in cycle 0, m_en in cycle 1, c_done in cycle 3 with c_rdata=0xDEAD_BEEF, busy high in cycles 1–3.
- Loader write addr=0x20, data=0x1234_5678, then core read of 0x20 -> l_done in cycle 2; core read returns 0x1234_5678; l_rdata remains 0.
- c_req and l_req held high continuously from reset -> grants alternate core, loader, core, loader; never two grants in one cycle; no starvation over 20 transactions.
- READ_LATENCY=3, core read -> c_done exactly 5 cycles after c_gnt; m_en high for exactly one cycle.
- rst asserted during WAIT of a core read -> outputs 0 immediately, no c_done; after release, a new l_req is granted first-tie-free and completes normally.
- Core write followed by c_req held high -> second c_gnt exactly 3 cycles after the first; c_rdata unchanged by the write.

Source files
------------

// File: rtl/unified_mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, owner encoding, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package unified_mem_arb_pkg;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_CNT_W        = 4;

    // Requester identity, also used as the round-robin history bit.
    localparam logic OWN_CORE   = 1'b0;
    localparam logic OWN_LOADER = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie, the requester that was not served last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is actually taken.
// Ports: i_req[0]=core, i_req[1]=loader; i_last_owner = previous winner;
//        o_gnt one-hot (all zero when nothing requests); o_winner = granted index.
module rr_arb2
    import unified_mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    always_comb begin
        o_winner = OWN_CORE;
        o_gnt    = 2'b00;
        case (i_req)
            2'b01:   o_winner = OWN_CORE;
            2'b10:   o_winner = OWN_LOADER;
            2'b11:   o_winner = ~i_last_owner;
            default: o_winner = OWN_CORE;
        endcase
        if (i_req != 2'b00) begin
            o_gnt = (o_winner == OWN_LOADER) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises core and loader accesses onto one memory macro with round-robin priority.
// Latency: grant in cycle 0, m_en in cycle 1, done in cycle 2 (write) or 2+READ_LATENCY (read).
// Backpressure: a requester holds req until its gnt; new requests are only granted in IDLE.
// Ports: clk/rst (async active-high); c_* core port; l_* loader port;
//        m_* memory macro port (m_en qualifies m_we/m_addr/m_wdata); busy = not IDLE.
module unified_mem_arbiter
    import unified_mem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
    logic           r_last_owner;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_c_rdata;
    logic [DW-1:0]  r_l_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]     w_gnt;
    logic           w_winner;
    logic           w_arb_open;
    logic           w_capture;
    logic           w_load_cnt;
    logic           w_rd_capture;

    rr_arb2 u_rr_arb2 (
        .i_req        ({l_req, c_req}),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_gnt),
        .o_winner     (w_winner)
    );

    // Grants are combinational from IDLE; masking with rst keeps every output low during reset.
    assign w_arb_open = (r_state == IDLE) && !rst;
    assign c_gnt      = w_arb_open && w_gnt[0];
    assign l_gnt      = w_arb_open && w_gnt[1];

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_load_cnt   = 1'b0;
        w_rd_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_state_nxt = RESP;
                end else begin
                    w_load_cnt  = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // <= 1 rather than == 1 so a zero count can never strand the FSM here.
                if (r_cnt <= CNT_W'(1)) begin
                    w_rd_capture = 1'b1;
                    w_state_nxt  = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CORE;
            r_last_owner <= OWN_LOADER;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_c_rdata    <= '0;
            r_l_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_we         <= (w_winner == OWN_LOADER) ? l_we    : c_we;
                r_addr       <= (w_winner == OWN_LOADER) ? l_addr  : c_addr;
                r_wdata      <= (w_winner == OWN_LOADER) ? l_wdata : c_wdata;
            end
            if (w_load_cnt) begin
                r_cnt <= CNT_W'(READ_LATENCY);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_capture) begin
                if (r_owner == OWN_LOADER) begin
                    r_l_rdata <= m_rdata;
                end else begin
                    r_c_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en    = (r_state == ISSUE);
    assign m_we    = m_en && r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign c_done  = (r_state == RESP) && (r_owner == OWN_CORE);
    assign l_done  = (r_state == RESP) && (r_owner == OWN_LOADER);
    assign c_rdata = r_c_rdata;
    assign l_rdata = r_l_rdata;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance A (READ_LATENCY=1) with a RAM model, instance B
// (READ_LATENCY=3) with a pattern memory. Table-driven transactions plus hand sequences.
// Backpressure: inputs driven #1 after posedge, outputs sampled at negedge.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instance A, READ_LATENCY = 1 ----------------
    logic        a_rst;
    logic        a_c_req, a_c_we, a_l_req, a_l_we;
    logic [31:0] a_c_addr, a_c_wdata, a_l_addr, a_l_wdata;
    logic        a_c_gnt, a_c_done, a_l_gnt, a_l_done;
    logic [31:0] a_c_rdata, a_l_rdata;
    logic        a_m_en, a_m_we, a_busy;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

    unified_mem_arbiter #(.AW(32), .DW(32), .READ_LATENCY(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(a_rst),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_gnt(a_c_gnt), .c_done(a_c_done), .c_rdata(a_c_rdata),
        .l_req(a_l_req), .l_we(a_l_we), .l_addr(a_l_addr), .l_wdata(a_l_wdata),
        .l_gnt(a_l_gnt), .l_done(a_l_done), .l_rdata(a_l_rdata),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_rdata(a_m_rdata), .busy(a_busy)
    );

    logic [31:0] mem_a [0:255];
    logic        mem_init = 1'b0;
    logic        pa_vld   = 1'b0;
    logic [31:0] pa_addr  = '0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) mem_a[j] <= 32'h0;
            mem_a[4] <= 32'hDEAD_BEEF;
        end else if (a_m_en && a_m_we) begin
            mem_a[a_m_addr[9:2]] <= a_m_wdata;
        end
        pa_vld  <= a_m_en && !a_m_we;
        pa_addr <= a_m_addr;
    end
    // Data is only valid in the one cycle the latency calls for; otherwise a poison value.
    assign a_m_rdata = pa_vld ? mem_a[pa_addr[9:2]] : 32'hBAD0_BAD0;

    // ---------------- instance B, READ_LATENCY = 3 ----------------
    logic        b_rst;
    logic        b_c_req, b_c_we, b_l_req, b_l_we;
    logic [31:0] b_c_addr, b_c_wdata, b_l_addr, b_l_wdata;
    logic        b_c_gnt, b_c_done, b_l_gnt, b_l_done;
    logic [31:0] b_c_rdata, b_l_rdata;
    logic        b_m_en, b_m_we, b_busy;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    unified_mem_arbiter #(.AW(32), .DW(32), .READ_LATENCY(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_done(b_c_done), .c_rdata(b_c_rdata),
        .l_req(b_l_req), .l_we(b_l_we), .l_addr(b_l_addr), .l_wdata(b_l_wdata),
        .l_gnt(b_l_gnt), .l_done(b_l_done), .l_rdata(b_l_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(b_m_rdata), .busy(b_busy)
    );

    logic [2:0]  pb_vld = 3'b0;
    logic [31:0] pb_addr [3];
    always @(posedge clk) begin
        pb_vld     <= {pb_vld[1:0], b_m_en && !b_m_we};
        pb_addr[0] <= b_m_addr;
        pb_addr[1] <= pb_addr[0];
        pb_addr[2] <= pb_addr[1];
    end
    assign b_m_rdata = pb_vld[2] ? (pb_addr[2] ^ 32'h5A5A_0000) : 32'hBAD0_BAD0;

    // ---------------- transaction table for instance A ----------------
    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        exp_core;     // 1 = core wins, 0 = loader wins
        int          exp_done;     // cycles from gnt to done
        logic [31:0] exp_c_rdata;
        logic [31:0] exp_l_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int done_cyc;
        int men_cnt;
        int gnt_cyc;
        int prev_gnt;
        int grants;
        int dbl;
        int dones;
        logic exp_core;

        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 3, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 2, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 3, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 3, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 2, 32'h1234_5678, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h30, 32'h0,         1'b0, 3, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 3, 32'h1234_5678, 32'hDEAD_BEEF};

        a_rst = 1'b1; b_rst = 1'b1;
        a_c_req = 0; a_c_we = 0; a_c_addr = 0; a_c_wdata = 0;
        a_l_req = 0; a_l_we = 0; a_l_addr = 0; a_l_wdata = 0;
        b_c_req = 0; b_c_we = 0; b_c_addr = 0; b_c_wdata = 0;
        b_l_req = 0; b_l_we = 0; b_l_addr = 0; b_l_wdata = 0;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy",    {31'b0, a_busy},   32'h0);
        check("rst_m_en",    {31'b0, a_m_en},   32'h0);
        check("rst_m_we",    {31'b0, a_m_we},   32'h0);
        check("rst_gnts",    {30'b0, a_c_gnt, a_l_gnt},   32'h0);
        check("rst_dones",   {30'b0, a_c_done, a_l_done}, 32'h0);
        check("rst_c_rdata", a_c_rdata, 32'h0);
        check("rst_l_rdata", a_l_rdata, 32'h0);
        check("rst_m_addr",  a_m_addr,  32'h0);

        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // ---------- table-driven transactions ----------
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            a_c_req = vecs[i].c_req; a_c_we = vecs[i].c_we;
            a_c_addr = vecs[i].c_addr; a_c_wdata = vecs[i].c_wdata;
            a_l_req = vecs[i].l_req; a_l_we = vecs[i].l_we;
            a_l_addr = vecs[i].l_addr; a_l_wdata = vecs[i].l_wdata;
            @(negedge clk);
            check($sformatf("v%0d_c_gnt", i), {31'b0, a_c_gnt}, {31'b0, vecs[i].exp_core});
            check($sformatf("v%0d_l_gnt", i), {31'b0, a_l_gnt}, {31'b0, !vecs[i].exp_core});
            @(posedge clk); #1;
            a_c_req = 0; a_l_req = 0;
            a_c_addr = 32'hFFFF_FFF0; a_l_addr = 32'hFFFF_FFF0;
            done_cyc = -1; men_cnt = 0;
            for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
                @(negedge clk);
                if (a_m_en) men_cnt++;
                if (k == 1) begin
                    check($sformatf("v%0d_busy", i), {31'b0, a_busy}, 32'h1);
                    check($sformatf("v%0d_m_addr", i), a_m_addr,
                          vecs[i].exp_core ? vecs[i].c_addr : vecs[i].l_addr);
                    check($sformatf("v%0d_m_we", i), {31'b0, a_m_we},
                          {31'b0, vecs[i].exp_core ? vecs[i].c_we : vecs[i].l_we});
                end
                if (a_c_done || a_l_done) begin
                    done_cyc = k;
                    check($sformatf("v%0d_c_done", i), {31'b0, a_c_done}, {31'b0, vecs[i].exp_core});
                    check($sformatf("v%0d_c_rdata", i), a_c_rdata, vecs[i].exp_c_rdata);
                    check($sformatf("v%0d_l_rdata", i), a_l_rdata, vecs[i].exp_l_rdata);
                end
            end
            check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_m_en_cycles", i), men_cnt, 1);
        end

        // ---------- core write then c_req held high: second grant 3 cycles later ----------
        @(posedge clk); #1;
        a_c_req = 1; a_c_we = 1; a_c_addr = 32'h40; a_c_wdata = 32'h0000_0055;
        @(negedge clk);
        check("wr_hold_first_gnt", {31'b0, a_c_gnt}, 32'h1);
        @(posedge clk); #1;
        a_c_we = 0; a_c_wdata = 32'h0;
        gnt_cyc = -1;
        for (int k = 1; k <= 20 && gnt_cyc < 0; k++) begin
            @(negedge clk);
            if (a_c_done) check("wr_hold_c_rdata_kept", a_c_rdata, 32'h1234_5678);
            if (a_c_gnt) gnt_cyc = k;
        end
        check("wr_hold_gnt_spacing", gnt_cyc, 3);
        @(posedge clk); #1;
        a_c_req = 0;
        done_cyc = -1;
        for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (a_c_done) done_cyc = k;
        end
        check("wr_hold_read_done", done_cyc, 3);
        check("wr_hold_readback", a_c_rdata, 32'h0000_0055);

        // ---------- continuous contention from reset ----------
        @(posedge clk); #1;
        a_rst = 1'b1;
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h10;
        a_l_req = 1; a_l_we = 0; a_l_addr = 32'h20;
        @(negedge clk);
        check("rst_with_req_gnts", {30'b0, a_c_gnt, a_l_gnt}, 32'h0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        exp_core = 1'b1; grants = 0; dbl = 0; prev_gnt = -1;
        for (int k = 0; k < 300 && grants < 20; k++) begin
            @(negedge clk);
            if (a_c_gnt && a_l_gnt) dbl++;
            if (a_c_gnt || a_l_gnt) begin
                check($sformatf("rr_g%0d_owner", grants), {31'b0, a_c_gnt}, {31'b0, exp_core});
                if (prev_gnt >= 0) check($sformatf("rr_g%0d_spacing", grants), k - prev_gnt, 4);
                prev_gnt = k;
                exp_core = !exp_core;
                grants++;
            end
        end
        check("rr_grant_count", grants, 20);
        check("rr_double_grants", dbl, 0);
        @(posedge clk); #1;
        a_c_req = 0; a_l_req = 0;

        // ---------- instance B: READ_LATENCY = 3 core read ----------
        @(posedge clk); #1;
        b_c_req = 1; b_c_we = 0; b_c_addr = 32'h100;
        @(negedge clk);
        check("rl3_c_gnt", {31'b0, b_c_gnt}, 32'h1);
        @(posedge clk); #1;
        b_c_req = 0;
        done_cyc = -1; men_cnt = 0;
        for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (b_m_en) men_cnt++;
            if (b_c_done) done_cyc = k;
        end
        check("rl3_done_cycle", done_cyc, 5);
        check("rl3_m_en_cycles", men_cnt, 1);
        check("rl3_c_rdata", b_c_rdata, 32'h5A5A_0100);

        // ---------- instance B: reset during WAIT ----------
        @(posedge clk); #1;
        b_c_req = 1; b_c_addr = 32'h200;
        @(negedge clk);
        check("rstw_c_gnt", {31'b0, b_c_gnt}, 32'h1);
        @(posedge clk); #1;
        b_c_req = 0;
        @(posedge clk); #3;
        b_rst = 1'b1;
        #1;
        check("rstw_busy", {31'b0, b_busy}, 32'h0);
        check("rstw_strobes", {29'b0, b_m_en, b_m_we, b_c_done}, 32'h0);
        check("rstw_c_rdata", b_c_rdata, 32'h0);
        @(posedge clk); #1;
        b_rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_c_done || b_l_done || b_busy) dones++;
        end
        check("rstw_no_done_after", dones, 0);
        @(posedge clk); #1;
        b_l_req = 1; b_l_we = 0; b_l_addr = 32'h300;
        @(negedge clk);
        check("rstw_l_gnt", {30'b0, b_c_gnt, b_l_gnt}, 32'h1);
        @(posedge clk); #1;
        b_l_req = 0;
        done_cyc = -1; dones = 0;
        for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (b_c_done) dones++;
            if (b_l_done) done_cyc = k;
        end
        check("rstw_l_done_cycle", done_cyc, 5);
        check("rstw_l_rdata", b_l_rdata, 32'h5A5A_0300);
        check("rstw_no_c_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
